// File: rtl/vec_requant.sv
// Per-lane requantizer: signed accumulator * unsigned scale, arithmetic right shift, saturate to FIXED_DATA_WIDTH.
// Define REQUANT_ROUND_EN to add round-half-up before the shift; the default build truncates (floor).
module vec_requant #(
  parameter int BUS_NUM          = 8,
  parameter int IN_DATA_WIDTH    = 24,
  parameter int SCALE_WIDTH      = 8,
  parameter int SCALA_POS_WIDTH  = 5,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int SAT_CNT_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_vld,
  input  logic [SCALE_WIDTH-1:0]                cfg_scale,
  input  logic [SCALA_POS_WIDTH-1:0]            cfg_shift,
  input  logic [BUS_NUM*IN_DATA_WIDTH-1:0]      in_data,
  input  logic [BUS_NUM-1:0]                    in_data_vld,
  output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]   out_fixed_data,
  output logic [BUS_NUM-1:0]                    out_fixed_data_vld,
  input  logic                                  sat_cnt_clr,
  output logic [SAT_CNT_WIDTH-1:0]              sat_cnt
);

  localparam int PW = IN_DATA_WIDTH + SCALE_WIDTH + 1;

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-FIXED_DATA_WIDTH+1){1'b0}}, {(FIXED_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-FIXED_DATA_WIDTH+1){1'b1}}, {(FIXED_DATA_WIDTH-1){1'b0}}};
  localparam logic [FIXED_DATA_WIDTH-1:0] FIX_MAX = {1'b0, {(FIXED_DATA_WIDTH-1){1'b1}}};
  localparam logic [FIXED_DATA_WIDTH-1:0] FIX_MIN = {1'b1, {(FIXED_DATA_WIDTH-1){1'b0}}};
  localparam logic [SCALE_WIDTH-1:0] SCALE_ONE = {{(SCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SAT_CNT_WIDTH:0] CNT_ONE = {{SAT_CNT_WIDTH{1'b0}}, 1'b1};

  logic [SCALE_WIDTH-1:0]          r_scale;
  logic [SCALA_POS_WIDTH-1:0]      r_shift;
  logic [BUS_NUM-1:0]              r_s1Vld;
  logic [BUS_NUM-1:0]              r_s2Vld;
  logic [BUS_NUM-1:0]              r_outVld;
  logic signed [PW-1:0]            r_s1Prod  [BUS_NUM];
  logic [SCALA_POS_WIDTH-1:0]      r_s1Shift [BUS_NUM];
  logic signed [PW-1:0]            r_s2Data  [BUS_NUM];
  logic [FIXED_DATA_WIDTH-1:0]     r_outData [BUS_NUM];
  logic [SAT_CNT_WIDTH-1:0]        r_satCnt;

  logic signed [PW-1:0]            w_inExt   [BUS_NUM];
  logic signed [PW-1:0]            w_scaleExt;
  logic signed [PW-1:0]            w_prod    [BUS_NUM];
  logic signed [PW-1:0]            w_shifted [BUS_NUM];
  logic [FIXED_DATA_WIDTH-1:0]     w_satData [BUS_NUM];
  logic [BUS_NUM-1:0]              w_clamp;
  logic [SAT_CNT_WIDTH:0]          w_clampCnt;
  logic [SAT_CNT_WIDTH:0]          w_satSum;
`ifdef REQUANT_ROUND_EN
  logic signed [PW-1:0]            w_round   [BUS_NUM];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scale <= SCALE_ONE;
      r_shift <= '0;
    end else if (cfg_vld) begin
      r_scale <= cfg_scale;
      r_shift <= cfg_shift;
    end
  end

  // Both operands are widened to the full product width so the multiply is exact.
  always_comb begin
    w_scaleExt = {{(PW-SCALE_WIDTH){1'b0}}, r_scale};
    for (int i = 0; i < BUS_NUM; i++) begin
      w_inExt[i] = {{(PW-IN_DATA_WIDTH){in_data[i*IN_DATA_WIDTH+IN_DATA_WIDTH-1]}},
                    in_data[i*IN_DATA_WIDTH +: IN_DATA_WIDTH]};
      w_prod[i]  = w_inExt[i] * w_scaleExt;
    end
  end

  always_comb begin
    for (int i = 0; i < BUS_NUM; i++) begin
`ifdef REQUANT_ROUND_EN
      w_round[i]   = (r_s1Shift[i] == '0) ? '0 :
                     ({{(PW-1){1'b0}}, 1'b1} << (r_s1Shift[i] - {{(SCALA_POS_WIDTH-1){1'b0}}, 1'b1}));
      w_shifted[i] = (r_s1Prod[i] + w_round[i]) >>> r_s1Shift[i];
`else
      w_shifted[i] = r_s1Prod[i] >>> r_s1Shift[i];
`endif
    end
  end

  always_comb begin
    w_clampCnt = '0;
    for (int i = 0; i < BUS_NUM; i++) begin
      w_clamp[i]   = 1'b0;
      w_satData[i] = r_s2Data[i][FIXED_DATA_WIDTH-1:0];
      if (r_s2Data[i] > SAT_MAX) begin
        w_satData[i] = FIX_MAX;
        w_clamp[i]   = 1'b1;
      end else if (r_s2Data[i] < SAT_MIN) begin
        w_satData[i] = FIX_MIN;
        w_clamp[i]   = 1'b1;
      end
      if (r_s2Vld[i] && w_clamp[i]) w_clampCnt = w_clampCnt + CNT_ONE;
    end
    w_satSum = {1'b0, r_satCnt} + w_clampCnt;
  end

  // Shift amount travels with each product so a config change never splits a datum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Vld  <= '0;
      r_s2Vld  <= '0;
      r_outVld <= '0;
      for (int i = 0; i < BUS_NUM; i++) begin
        r_s1Prod[i]  <= '0;
        r_s1Shift[i] <= '0;
        r_s2Data[i]  <= '0;
        r_outData[i] <= '0;
      end
    end else begin
      r_s1Vld  <= in_data_vld;
      r_s2Vld  <= r_s1Vld;
      r_outVld <= r_s2Vld;
      for (int i = 0; i < BUS_NUM; i++) begin
        if (in_data_vld[i]) begin
          r_s1Prod[i]  <= w_prod[i];
          r_s1Shift[i] <= r_shift;
        end
        if (r_s1Vld[i]) r_s2Data[i]  <= w_shifted[i];
        if (r_s2Vld[i]) r_outData[i] <= w_satData[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_satCnt <= '0;
    end else if (sat_cnt_clr) begin
      r_satCnt <= '0;
    end else if (w_satSum[SAT_CNT_WIDTH]) begin
      r_satCnt <= '1;
    end else begin
      r_satCnt <= w_satSum[SAT_CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    out_fixed_data = '0;
    for (int i = 0; i < BUS_NUM; i++) begin
      out_fixed_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] = r_outData[i];
    end
  end

  assign out_fixed_data_vld = r_outVld;
  assign sat_cnt            = r_satCnt;

endmodule

// File: tb/tb_vec_requant.sv
// Scoreboard bench for vec_requant: a behavioural model queues expected lanes at drive time, a monitor compares at output.
// Honors REQUANT_ROUND_EN the same way the design does.
module tb_vec_requant;

  logic        clk;
  logic        rst_n;
  logic        cfg_vld;
  logic [7:0]  cfg_scale;
  logic [4:0]  cfg_shift;
  logic [191:0] in_data;
  logic [7:0]  in_data_vld;
  logic [63:0] out_fixed_data;
  logic [7:0]  out_fixed_data_vld;
  logic        sat_cnt_clr;
  logic [15:0] sat_cnt;

  typedef struct {
    longint      due;
    logic [7:0]  vld;
    logic [63:0] data;
  } entry_t;

  entry_t     q[$];
  entry_t     monEntry;
  int         laneVal[8];
  logic [7:0] lastOut[8];
  int         mScale;
  int         mShift;
  longint     mSatCnt;
  longint     cycleCnt;
  int         checkCnt;
  int         errCnt;

  vec_requant dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_vld            (cfg_vld),
    .cfg_scale          (cfg_scale),
    .cfg_shift          (cfg_shift),
    .in_data            (in_data),
    .in_data_vld        (in_data_vld),
    .out_fixed_data     (out_fixed_data),
    .out_fixed_data_vld (out_fixed_data_vld),
    .sat_cnt_clr        (sat_cnt_clr),
    .sat_cnt            (sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt = cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCnt++;
    if (observed !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] requantModel(input int x, input int sc, input int sh, output bit clamped);
    longint p;
    p = longint'(x) * longint'(sc);
`ifdef REQUANT_ROUND_EN
    if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
`endif
    p = p >>> sh;
    clamped = 1'b0;
    if (p > 127) begin
      clamped = 1'b1;
      return 8'h7f;
    end
    if (p < -128) begin
      clamped = 1'b1;
      return 8'h80;
    end
    return p[7:0];
  endfunction

  // One input cycle: drive, push the expected output, then let any config take effect for later data.
  task automatic applyStimulus(input logic [7:0] vld, input logic cfgV, input logic [7:0] sc, input logic [4:0] sh);
    entry_t e;
    bit     clamped;
    @(posedge clk); #1;
    in_data_vld = vld;
    cfg_vld     = cfgV;
    cfg_scale   = sc;
    cfg_shift   = sh;
    for (int i = 0; i < 8; i++) in_data[i*24 +: 24] = laneVal[i][23:0];
    if (vld != 8'h00) begin
      e.due = cycleCnt + 3;
      e.vld = vld;
      for (int i = 0; i < 8; i++) begin
        if (vld[i]) begin
          lastOut[i] = requantModel(laneVal[i], mScale, mShift, clamped);
          if (clamped && mSatCnt < 65535) mSatCnt++;
        end
        e.data[i*8 +: 8] = lastOut[i];
      end
      q.push_back(e);
    end
    if (cfgV) begin
      mScale = int'(sc);
      mShift = int'(sh);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(8'h00, 1'b0, 8'h00, 5'd0);
  endtask

  task automatic drainWait();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n       = 1'b0;
    in_data_vld = '0;
    cfg_vld     = 1'b0;
    in_data     = '0;
    q.delete();
    for (int i = 0; i < 8; i++) lastOut[i] = 8'h00;
    mScale  = 1;
    mShift  = 0;
    mSatCnt = 0;
    #1;
    checkOutput("rstData", out_fixed_data, 64'd0);
    checkOutput("rstVld", {56'd0, out_fixed_data_vld}, 64'd0);
    checkOutput("rstSatCnt", {48'd0, sat_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_fixed_data_vld != 8'h00) begin
        if (q.size() == 0) begin
          checkOutput("spuriousVld", {56'd0, out_fixed_data_vld}, 64'd0);
        end else begin
          monEntry = q.pop_front();
          checkOutput("latency", cycleCnt, monEntry.due);
          checkOutput("laneVld", {56'd0, out_fixed_data_vld}, {56'd0, monEntry.vld});
          checkOutput("laneData", out_fixed_data, monEntry.data);
        end
      end else if (q.size() > 0 && q[0].due <= cycleCnt) begin
        checkOutput("missingVld", 64'd0, {56'd0, q[0].vld});
        void'(q.pop_front());
      end
    end
  end

  initial begin
    checkCnt    = 0;
    errCnt      = 0;
    rst_n       = 1'b1;
    cfg_vld     = 1'b0;
    cfg_scale   = '0;
    cfg_shift   = '0;
    in_data     = '0;
    in_data_vld = '0;
    sat_cnt_clr = 1'b0;
    mScale      = 1;
    mShift      = 0;
    mSatCnt     = 0;
    for (int i = 0; i < 8; i++) begin
      laneVal[i] = 0;
      lastOut[i] = 8'h00;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("initData", out_fixed_data, 64'd0);
    checkOutput("initVld", {56'd0, out_fixed_data_vld}, 64'd0);
    checkOutput("initSatCnt", {48'd0, sat_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity config out of reset
    laneVal[0] = 100;
    applyStimulus(8'h01, 1'b0, 8'h00, 5'd0);
    idle(1);
    drainWait();
    checkOutput("defaultLane0", {56'd0, out_fixed_data[7:0]}, 64'd100);
    checkOutput("defaultSatCnt", {48'd0, sat_cnt}, 64'd0);

    // Rounding versus floor at shift 2
    applyStimulus(8'h00, 1'b1, 8'd1, 5'd2);
    laneVal[0] = 302;
    laneVal[1] = -302;
    applyStimulus(8'h03, 1'b0, 8'h00, 5'd0);
    idle(1);
    drainWait();
`ifdef REQUANT_ROUND_EN
    checkOutput("roundPos", {56'd0, out_fixed_data[7:0]}, 64'h4c);
    checkOutput("roundNeg", {56'd0, out_fixed_data[15:8]}, 64'hb5);
`else
    checkOutput("roundPos", {56'd0, out_fixed_data[7:0]}, 64'h4b);
    checkOutput("roundNeg", {56'd0, out_fixed_data[15:8]}, 64'hb4);
`endif

    // Saturation and its counter
    applyStimulus(8'h00, 1'b1, 8'd1, 5'd0);
    laneVal[0] = 1000;
    laneVal[1] = -1000;
    laneVal[2] = 50;
    applyStimulus(8'h07, 1'b0, 8'h00, 5'd0);
    idle(1);
    drainWait();
    checkOutput("satLanes", {40'd0, out_fixed_data[23:0]}, 64'h32807f);
    checkOutput("satCntTwo", {48'd0, sat_cnt}, 64'd2);

    // Clear held across a clamping lane wins over the increment
    sat_cnt_clr = 1'b1;
    laneVal[0]  = 5000;
    applyStimulus(8'h01, 1'b0, 8'h00, 5'd0);
    idle(4);
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
    mSatCnt     = 0;
    drainWait();
    checkOutput("satClr", {48'd0, sat_cnt}, 64'd0);

    // Config strobe coincident with data applies only to the next datum
    laneVal[0] = 10;
    applyStimulus(8'h01, 1'b1, 8'd2, 5'd0);
    applyStimulus(8'h01, 1'b0, 8'h00, 5'd0);
    idle(1);
    drainWait();
    checkOutput("cfgRace", {56'd0, out_fixed_data[7:0]}, 64'd20);

    // Masked lanes hold while the mask repeats back-to-back
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 8; i++) laneVal[i] = int'($urandom_range(400)) - 200;
      applyStimulus(8'b1010_0101, 1'b0, 8'h00, 5'd0);
    end
    idle(1);
    drainWait();

    // Random data, masks and mid-flight config changes
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < 8; i++) laneVal[i] = int'($urandom_range(16777215)) - 8388608;
      applyStimulus(8'($urandom_range(255)), 1'($urandom_range(1)),
                    8'($urandom_range(255)), 5'($urandom_range(31)));
    end
    idle(1);
    drainWait();
    checkOutput("randSatCnt", {48'd0, sat_cnt}, 64'(mSatCnt));

    // Reset with two transfers in flight, then confirm clean restart latency
    laneVal[0] = 7;
    laneVal[3] = 9;
    applyStimulus(8'h09, 1'b0, 8'h00, 5'd0);
    applyStimulus(8'h09, 1'b0, 8'h00, 5'd0);
    doReset();
    idle(6);
    laneVal[0] = 33;
    applyStimulus(8'h01, 1'b0, 8'h00, 5'd0);
    idle(1);
    drainWait();
    checkOutput("postRstLane0", {56'd0, out_fixed_data[7:0]}, 64'd33);
    checkOutput("postRstSatCnt", {48'd0, sat_cnt}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
